alu_arbiter: RTL and testbench

Shares the single 32-bit ALU between two requesters: port 0 is the integer execute path and port 1 is the branch/compare path. Each port uses a valid/ready request handshake and a valid/ready response handshake. Arbitration is round-robin. The block registers operands, sequences one ALU operation at a time, and holds the captured result/branch until the owning requester accepts it. It sits between the decode/issue logic and the ALU instance.

---
 rtl/alu_arbiter_if.sv | 26 ++
 rtl/alu_arbiter.sv | 173 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: one requester channel of the shared-ALU arbiter.
// Request side carries operands and op-code; response side returns result and branch.
interface alu_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 4
);
   logic              req_valid;
   logic              req_ready;
   logic [DATA_W-1:0] req_data0;
   logic [DATA_W-1:0] req_data1;
   logic [CTRL_W-1:0] req_ctrl;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_result;
   logic              rsp_branch;

   modport master (
      output req_valid, req_data0, req_data1, req_ctrl, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_branch
   );

   modport slave (
      input  req_valid, req_data0, req_data1, req_ctrl, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_branch
   );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one ALU between the execute path (p0)
// and the branch/compare path (p1).
// Ports:
//   clk, reset      - clock; synchronous active-high reset
//   p0, p1          - requester channels (request + response handshakes)
//   alu_reset       - ALU reset, mirrors reset
//   alu_data0/1     - registered operands to the ALU
//   alu_ctrl        - registered op-code to the ALU
//   alu_result      - ALU result, combinational from alu_*
//   alu_branch      - ALU branch flag
//   op_count        - completed response handshakes, wrapping
module alu_arbiter #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   alu_arbiter_if.slave      p0,
   alu_arbiter_if.slave      p1,
   output logic              alu_reset,
   output logic [DATA_W-1:0] alu_data0,
   output logic [DATA_W-1:0] alu_data1,
   output logic [CTRL_W-1:0] alu_ctrl,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_branch,
   output logic [CNT_W-1:0]  op_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_q, last_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [CTRL_W-1:0] op_q, op_d;
   logic              vld0_q, vld0_d;
   logic              vld1_q, vld1_d;
   logic [DATA_W-1:0] res0_q, res0_d;
   logic [DATA_W-1:0] res1_q, res1_d;
   logic              br0_q, br0_d;
   logic              br1_q, br1_d;
   logic [CNT_W-1:0]  op_count_q, op_count_d;

   logic              win;
   logic              idle;
   logic              rdy0;
   logic              rdy1;
   logic              acc;
   logic              rsp_hs;

   // Lone valid port wins; on a tie the port that did not win last goes.
   always_comb begin
      win = p1.req_valid;
      if (p0.req_valid && p1.req_valid) begin
         win = ~last_q;
      end
   end

   assign idle = (state_q == IDLE) && !reset;
   assign rdy0 = idle && p0.req_valid && !win;
   assign rdy1 = idle && p1.req_valid && win;
   assign acc  = rdy0 | rdy1;

   assign rsp_hs = owner_q ? (vld1_q && p1.rsp_ready)
                           : (vld0_q && p0.rsp_ready);

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      last_d     = last_q;
      a_d        = a_q;
      b_d        = b_q;
      op_d       = op_q;
      vld0_d     = vld0_q;
      vld1_d     = vld1_q;
      res0_d     = res0_q;
      res1_d     = res1_q;
      br0_d      = br0_q;
      br1_d      = br1_q;
      op_count_d = op_count_q;
      unique case (state_q)
         IDLE: begin
            if (acc) begin
               a_d     = win ? p1.req_data0 : p0.req_data0;
               b_d     = win ? p1.req_data1 : p0.req_data1;
               op_d    = win ? p1.req_ctrl  : p0.req_ctrl;
               owner_d = win;
               last_d  = win;
               state_d = EXEC;
            end
         end
         EXEC: begin
            // ALU output has settled from the registered operands.
            if (owner_q) begin
               res1_d = alu_result;
               br1_d  = alu_branch;
               vld1_d = 1'b1;
            end else begin
               res0_d = alu_result;
               br0_d  = alu_branch;
               vld0_d = 1'b1;
            end
            state_d = RESP;
         end
         RESP: begin
            if (rsp_hs) begin
               vld0_d     = 1'b0;
               vld1_d     = 1'b0;
               op_count_d = op_count_q + 1'b1;
               state_d    = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         owner_q    <= 1'b0;
         last_q     <= 1'b1;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         vld0_q     <= 1'b0;
         vld1_q     <= 1'b0;
         res0_q     <= '0;
         res1_q     <= '0;
         br0_q      <= 1'b0;
         br1_q      <= 1'b0;
         op_count_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         last_q     <= last_d;
         a_q        <= a_d;
         b_q        <= b_d;
         op_q       <= op_d;
         vld0_q     <= vld0_d;
         vld1_q     <= vld1_d;
         res0_q     <= res0_d;
         res1_q     <= res1_d;
         br0_q      <= br0_d;
         br1_q      <= br1_d;
         op_count_q <= op_count_d;
      end
   end

   assign p0.req_ready  = rdy0;
   assign p0.rsp_valid  = vld0_q;
   assign p0.rsp_result = res0_q;
   assign p0.rsp_branch = br0_q;

   assign p1.req_ready  = rdy1;
   assign p1.rsp_valid  = vld1_q;
   assign p1.rsp_result = res1_q;
   assign p1.rsp_branch = br1_q;

   assign alu_reset = reset;
   assign alu_data0 = a_q;
   assign alu_data1 = b_q;
   assign alu_ctrl  = op_q;
   assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a behavioural ALU.
// Expected results are queued at request acceptance and checked at response.
module tb_alu_arbiter;

   localparam int DW = 32;
   localparam int CW = 4;
   localparam int NW = 16;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_SLL  = 4'd2;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_BLT  = 4'd12;
   localparam logic [3:0] OP_BLTU = 4'd14;

   typedef struct packed {
      logic [31:0] res;
      logic        br;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          alu_reset;
   logic [DW-1:0] alu_data0;
   logic [DW-1:0] alu_data1;
   logic [DW-1:0] alu_result;
   logic [CW-1:0] alu_ctrl;
   logic          alu_branch;
   logic [NW-1:0] op_count;

   int            total = 0;
   int            bad = 0;
   int            cyc = 0;
   logic [NW-1:0] mcnt = '0;
   exp_t          q0[$];
   exp_t          q1[$];
   exp_t          cur0;
   exp_t          cur1;
   int            glog[$];
   int            gcyc[$];
   int            acc0 = 0;
   int            acc1 = 0;
   logic          pv0 = 1'b0;
   logic          pv1 = 1'b0;

   always #5 clk = ~clk;

   alu_arbiter_if #(.DATA_W(DW), .CTRL_W(CW)) p0 ();
   alu_arbiter_if #(.DATA_W(DW), .CTRL_W(CW)) p1 ();

   alu_arbiter #(
      .DATA_W(DW),
      .CTRL_W(CW),
      .CNT_W (NW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .p0        (p0),
      .p1        (p1),
      .alu_reset (alu_reset),
      .alu_data0 (alu_data0),
      .alu_data1 (alu_data1),
      .alu_ctrl  (alu_ctrl),
      .alu_result(alu_result),
      .alu_branch(alu_branch),
      .op_count  (op_count)
   );

   always_comb begin
      alu_result = '0;
      alu_branch = 1'b0;
      case (alu_ctrl)
         4'd0:  alu_result = alu_data0 + alu_data1;
         4'd1:  alu_result = alu_data0 - alu_data1;
         4'd2:  alu_result = alu_data0 << alu_data1[4:0];
         4'd3:  alu_result = {31'd0, $signed(alu_data0) < $signed(alu_data1)};
         4'd4:  alu_result = {31'd0, alu_data0 < alu_data1};
         4'd5:  alu_result = alu_data0 ^ alu_data1;
         4'd6:  alu_result = alu_data0 >> alu_data1[4:0];
         4'd7:  alu_result = $signed(alu_data0) >>> alu_data1[4:0];
         4'd8:  alu_result = alu_data0 | alu_data1;
         4'd9:  alu_result = alu_data0 & alu_data1;
         4'd10: alu_branch = alu_data0 == alu_data1;
         4'd11: alu_branch = alu_data0 != alu_data1;
         4'd12: alu_branch = $signed(alu_data0) < $signed(alu_data1);
         4'd13: alu_branch = $signed(alu_data0) >= $signed(alu_data1);
         4'd14: alu_branch = alu_data0 < alu_data1;
         default: alu_branch = alu_data0 >= alu_data1;
      endcase
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      cyc++;
      chk("cnt", op_count, mcnt);
      chk("rdy_excl", p0.req_ready & p1.req_ready, 0);
      chk("vld_excl", p0.rsp_valid & p1.rsp_valid, 0);
      if (reset) begin
         chk("rst_rdy", {p0.req_ready, p1.req_ready}, 0);
         q0.delete();
         q1.delete();
         mcnt = '0;
         pv0 = 1'b0;
         pv1 = 1'b0;
      end else begin
         if (p0.req_valid && p0.req_ready) begin
            q0.push_back(cur0);
            glog.push_back(0);
            gcyc.push_back(cyc);
            acc0 = cyc;
         end
         if (p1.req_valid && p1.req_ready) begin
            q1.push_back(cur1);
            glog.push_back(1);
            gcyc.push_back(cyc);
            acc1 = cyc;
         end
         if (p0.rsp_valid && !pv0) chk("lat0", cyc - acc0, 2);
         if (p1.rsp_valid && !pv1) chk("lat1", cyc - acc1, 2);
         if (p0.rsp_valid && p0.rsp_ready) begin
            chk("sb0_has", q0.size() != 0, 1);
            if (q0.size() != 0) begin
               e = q0.pop_front();
               chk("res0", p0.rsp_result, e.res);
               chk("br0", p0.rsp_branch, e.br);
            end
            mcnt = mcnt + 1'b1;
         end
         if (p1.rsp_valid && p1.rsp_ready) begin
            chk("sb1_has", q1.size() != 0, 1);
            if (q1.size() != 0) begin
               e = q1.pop_front();
               chk("res1", p1.rsp_result, e.res);
               chk("br1", p1.rsp_branch, e.br);
            end
            mcnt = mcnt + 1'b1;
         end
         pv0 = p0.rsp_valid;
         pv1 = p1.rsp_valid;
      end
   end

   task automatic set_req(input int port, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic eb);
      if (port == 0) begin
         p0.req_data0 = a;
         p0.req_data1 = b;
         p0.req_ctrl  = op;
         cur0 = '{res: er, br: eb};
         p0.req_valid = 1'b1;
      end else begin
         p1.req_data0 = a;
         p1.req_data1 = b;
         p1.req_ctrl  = op;
         cur1 = '{res: er, br: eb};
         p1.req_valid = 1'b1;
      end
   endtask

   task automatic wait_acc(input int port);
      logic ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (port == 0 ? (p0.req_valid && p0.req_ready)
                       : (p1.req_valid && p1.req_ready)) begin
            ok = 1'b1;
            break;
         end
      end
      chk("acc_to", ok, 1);
      @(posedge clk);
      #1;
      if (port == 0) p0.req_valid = 1'b0;
      else p1.req_valid = 1'b0;
   endtask

   task automatic drain();
      logic done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (q0.size() == 0 && q1.size() == 0 && !p0.rsp_valid &&
             !p1.rsp_valid && !p0.req_valid && !p1.req_valid) begin
            done = 1'b1;
            break;
         end
      end
      chk("drain", done, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      logic ok;
      p0.req_valid = 1'b0;
      p0.req_data0 = '0;
      p0.req_data1 = '0;
      p0.req_ctrl  = '0;
      p0.rsp_ready = 1'b1;
      p1.req_valid = 1'b0;
      p1.req_data0 = '0;
      p1.req_data1 = '0;
      p1.req_ctrl  = '0;
      p1.rsp_ready = 1'b1;
      cur0 = '0;
      cur1 = '0;

      // reset state
      @(negedge clk);
      chk("rst_alu_reset", alu_reset, 1);
      chk("rst_vld", {p0.rsp_valid, p1.rsp_valid}, 0);
      chk("rst_res", {p0.rsp_result, p1.rsp_result}, 0);
      chk("rst_br", {p0.rsp_branch, p1.rsp_branch}, 0);
      chk("rst_alu_in", {alu_data0, alu_data1, alu_ctrl}, 0);
      chk("rst_cnt", op_count, 0);
      @(posedge clk);
      #1 reset = 1'b0;

      // 1: single ADD on port 0, operands changed after accept
      set_req(0, OP_ADD, 32'd5, 32'd7, 32'd12, 1'b0);
      @(negedge clk);
      chk("t1_rdy", p0.req_ready, 1);
      @(posedge clk);
      #1;
      p0.req_valid = 1'b0;
      p0.req_data0 = 32'd99;
      @(negedge clk);
      chk("t1_exec_vld", p0.rsp_valid, 0);
      @(negedge clk);
      chk("t1_vld", p0.rsp_valid, 1);
      chk("t1_res", p0.rsp_result, 12);
      drain();
      chk("t1_cnt", op_count, 1);

      // 2: both ports continuously valid, round-robin
      pulse_reset();
      glog.delete();
      gcyc.delete();
      set_req(0, OP_SUB, 32'd10, 32'd3, 32'd7, 1'b0);
      set_req(1, OP_SUB, 32'd10, 32'd3, 32'd7, 1'b0);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (glog.size() >= 4) begin
            ok = 1'b1;
            break;
         end
      end
      chk("t2_to", ok, 1);
      @(posedge clk);
      #1;
      p0.req_valid = 1'b0;
      p1.req_valid = 1'b0;
      drain();
      chk("t2_n", glog.size(), 4);
      for (int i = 0; i < 4 && i < glog.size(); i++) begin
         chk("t2_grant", glog[i], i % 2);
         if (i > 0) chk("t2_gap", gcyc[i] - gcyc[i-1], 3);
      end
      chk("t2_cnt", op_count, 4);

      // 3: signed vs unsigned compare on port 1
      set_req(1, OP_BLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
      wait_acc(1);
      drain();
      chk("t3_blt_br", p1.rsp_branch, 1);
      chk("t3_blt_res", p1.rsp_result, 0);
      set_req(1, OP_BLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
      wait_acc(1);
      drain();
      chk("t3_bltu_br", p1.rsp_branch, 0);

      // 4: backpressure on port 0 while port 1 waits
      glog.delete();
      p0.rsp_ready = 1'b0;
      set_req(1, OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0);
      set_req(0, OP_SLL, 32'd1, 32'd4, 32'd16, 1'b0);
      wait_acc(0);
      @(negedge clk);
      repeat (5) begin
         @(negedge clk);
         chk("t4_vld", p0.rsp_valid, 1);
         chk("t4_res", p0.rsp_result, 16);
         chk("t4_rdy1", p1.req_ready, 0);
      end
      @(posedge clk);
      #1 p0.rsp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("t4_rdy1_idle", p1.req_ready, 1);
      chk("t4_vld_drop", p0.rsp_valid, 0);
      chk("t4_hold", p0.rsp_result, 16);
      @(posedge clk);
      #1 p1.req_valid = 1'b0;
      drain();
      chk("t4_n", glog.size(), 2);
      if (glog.size() == 2) begin
         chk("t4_g0", glog[0], 0);
         chk("t4_g1", glog[1], 1);
      end

      // 5: reset during EXEC aborts and restores priority
      pulse_reset();
      set_req(0, OP_XOR, 32'hF0, 32'hFF, 32'h0F, 1'b0);
      wait_acc(0);
      reset = 1'b1;
      @(negedge clk);
      chk("t5_alu_reset", alu_reset, 1);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("t5_vld", {p0.rsp_valid, p1.rsp_valid}, 0);
      chk("t5_cnt", op_count, 0);
      glog.delete();
      @(posedge clk);
      #1;
      set_req(0, OP_XOR, 32'hA5, 32'h5A, 32'hFF, 1'b0);
      set_req(1, OP_XOR, 32'h3, 32'h1, 32'h2, 1'b0);
      wait_acc(0);
      wait_acc(1);
      drain();
      chk("t5_n", glog.size(), 2);
      if (glog.size() >= 1) chk("t5_first", glog[0], 0);

      // 6: op_count wrap
      force dut.op_count_q = 16'hFFFF;
      mcnt = 16'hFFFF;
      @(posedge clk);
      #1 release dut.op_count_q;
      @(negedge clk);
      chk("t6_pre", op_count, 16'hFFFF);
      @(posedge clk);
      #1;
      set_req(1, OP_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0);
      wait_acc(1);
      drain();
      chk("t6_wrap", op_count, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
